dram_port_arbiter: RTL and testbench
====================================

// Module: dram_port_arbiter
// PURPOSE
//  Shares the single DRAM port between the instruction cache (loads only) and the data cache (loads and write-through).
//  Each cache pulses its request for one cycle. This block captures the request, grants the port round-robin, and issues
//  exactly one DRAM transaction at a time. It routes valid/written back to the owner. Sits between the caches and the DRAM controller.
// PARAMETERS
//  MEM_SCALE  27  byte-address width of DRAM
// PORTS
//  clk        in   1          clock; single clock domain
//  rst        in   1          synchronous reset, active-high
//  i_oe       in   1          icache load request pulse (1 cycle)
//  i_addr     in   MEM_SCALE  icache load address (word aligned)
//  i_rdata    out  32         load data (shared bus with d_rdata)
//  i_valid    out  1          icache load data valid
//  d_oe       in   1          dcache request pulse (1 cycle)
//  d_addr     in   MEM_SCALE  dcache address
//  d_wdata    in   32         dcache write data
//  d_we       in   4          byte write enables; 0 = load
//  d_rdata    out  32         load data
//  d_valid    out  1          dcache load data valid
//  d_written  out  1          dcache write completed
//  mem_oe     out  1          DRAM request pulse (1 cycle)
//  mem_addr   out  MEM_SCALE  DRAM address
//  mem_wdata  out  32         DRAM write data
//  mem_we     out  4          DRAM byte enables
//  mem_rdata  in   32         DRAM load data
//  mem_valid  in   1          DRAM load data valid
//  mem_written in  1          DRAM write done
// BEHAVIOUR
//  - Request slots: one per requester (pend, addr, wdata, we). The slot captures on *_oe.
//    The slot clears the cycle its request is issued on mem_oe.
//    Capture in the same cycle as a clear: capture wins, so back-to-back requests are legal.
//  - *_oe while that slot is still pending or in flight is a protocol violation: $display + $finish in simulation.
//  - FSM IDLE -> ISSUE -> WAIT -> IDLE. Encoding is 2 bits.
//    IDLE: if any slot is pending, pick owner, go to ISSUE.
//      Only one pending: grant it.
//      Both pending: grant the one not granted last (last_gnt pointer; reset value = D, so I wins the first tie).
//    ISSUE: mem_oe=1 for exactly one cycle with the owner slot contents.
//      I-side: mem_we=0. D-side: mem_we=d slot we.
//      Then go to WAIT; last_gnt <= owner.
//    WAIT, owner load: leave on mem_valid. WAIT, owner write: leave on mem_written. Next state is IDLE.
//  - Latency: a request captured at T, with the FSM IDLE and no contention, gives mem_oe at T+2.
//    IDLE decides at T+1; ISSUE drives at T+2.
//  - Responses are combinational pass-through:
//    - i_valid = mem_valid & state==WAIT & owner==I.
//    - d_valid = mem_valid & WAIT & owner==D & load.
//    - d_written = mem_written & WAIT & owner==D & write.
//    - i_rdata = d_rdata = mem_rdata.
//  - mem_valid/mem_written outside WAIT, or of the wrong kind, is ignored: no output, no state change.
//  - mem_addr/mem_wdata/mem_we hold the last issued values outside ISSUE.
//  - Reset values: state=IDLE, slots empty, last_gnt=D, mem_oe=0, mem_we=0, mem_addr=0, mem_wdata=0.
//    All *_valid/d_written = 0.
//  - Reset mid-operation: in-flight and pending requests are dropped. A late DRAM response after reset is ignored (state=IDLE).
// CONFIGURATION
//  Macro DRAM_ARB_STAT_EN.
//  - Defined: adds outputs arb_cnt_i, arb_cnt_d, arb_cnt_conflict (32 bits each, reset 0, wrap-around).
//    arb_cnt_i / arb_cnt_d: +1 per ISSUE for that owner.
//    arb_cnt_conflict: +1 per IDLE decision with both slots pending.
//  - Undefined: these ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  - State encodings and the owner codes (OWN_I=0, OWN_D=1) go in the shared header next to UTIL.v definitions.
//  - One sub-module: arb_req_slot (capture/clear register with a pending flag), instantiated twice.
//    The I instance ties wdata=0 and we=0.
// TESTING
//  1. i_oe addr=0x100, DRAM answers mem_valid 3 cycles after mem_oe, rdata=0xDEADBEEF
//     -> mem_oe at T+2, addr 0x100, we=0; i_valid=1 with 0xDEADBEEF; d_valid=0.
//  2. d_oe we=4'b0011 addr=0x204 wdata=0x1234
//     -> mem_we=0011, mem_addr=0x204; on mem_written, d_written=1 for 1 cycle; no i/d_valid.
//  3. i_oe and d_oe in the same cycle after reset -> I issued first, then D.
//     Repeat the pair: D first, then I (alternation); DRAM_ARB_STAT_EN conflict counter = 2.
//  4. d_oe load issued; i_oe arrives during WAIT
//     -> I held pending, issued only after d_valid; exactly one mem_oe per request.
//  5. rst asserted during WAIT, mem_valid arrives 2 cycles later
//     -> no i_valid/d_valid, state IDLE, mem_oe stays 0, counters 0.
//  6. d_oe again in the same cycle its d_valid fires -> accepted, issued next round; no $finish.

Source files
------------

// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and constants for the DRAM port arbiter.
// Optional statistics counters are enabled with the DRAM_ARB_STAT_EN macro.
package dram_port_arbiter_pkg;

  localparam int unsigned MEM_SCALE_DEF = 27;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned WE_W          = 4;
  localparam int unsigned STAT_W        = 32;

  // Arbiter FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Port owner codes
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last
  function automatic owner_e pick_owner(input logic i_pend,
                                        input logic d_pend,
                                        input owner_e last_gnt);
    owner_e res;
    if (i_pend && d_pend) begin
      res = (last_gnt == OWN_D) ? OWN_I : OWN_D;
    end else if (d_pend) begin
      res = OWN_D;
    end else begin
      res = OWN_I;
    end
    return res;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_arb_req_slot.sv
// One captured request per requester: pending flag plus address, write data and byte enables.
// A capture in the same cycle as a clear wins, so a requester may re-request back to back.
module arb_req_slot
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_SCALE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [WE_W-1:0]   we,
  output logic              pend,
  output logic [ADDR_W-1:0] q_addr,
  output logic [DATA_W-1:0] q_wdata,
  output logic [WE_W-1:0]   q_we
);

  // Capture on request pulse, drop pending once the request has been issued
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_we    <= '0;
    end else if (cap) begin
      pend    <= 1'b1;
      q_addr  <= addr;
      q_wdata <= wdata;
      q_we    <= we;
    end else if (clr) begin
      pend    <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single DRAM port between the icache (loads) and the dcache (loads and writes).
// Requests are captured in per-requester slots, granted round-robin and issued one at a time.
// Define DRAM_ARB_STAT_EN to add grant/conflict statistics counters.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_SCALE = MEM_SCALE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_oe,
  input  logic [MEM_SCALE-1:0] i_addr,
  output logic [DATA_W-1:0]    i_rdata,
  output logic                 i_valid,
  input  logic                 d_oe,
  input  logic [MEM_SCALE-1:0] d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  input  logic [WE_W-1:0]      d_we,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 d_valid,
  output logic                 d_written,
  output logic                 mem_oe,
  output logic [MEM_SCALE-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [WE_W-1:0]      mem_we,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_valid,
  input  logic                 mem_written
`ifdef DRAM_ARB_STAT_EN
  ,
  output logic [STAT_W-1:0]    arb_cnt_i,
  output logic [STAT_W-1:0]    arb_cnt_d,
  output logic [STAT_W-1:0]    arb_cnt_conflict
`endif
);

  arb_state_e state;
  owner_e     owner;
  owner_e     last_gnt;
  owner_e     pick;
  logic       own_write;
  logic       wait_done;

  logic                 i_pend, d_pend;
  logic                 i_clr, d_clr;
  logic                 i_busy, d_busy;
  logic [MEM_SCALE-1:0] i_q_addr, d_q_addr;
  logic [DATA_W-1:0]    i_q_wdata, d_q_wdata;
  logic [WE_W-1:0]      i_q_we, d_q_we;

  // Icache slot: loads only, so write data and enables are tied off
  arb_req_slot #(.ADDR_W(MEM_SCALE)) u_slot_i (
    .clk     (clk),
    .rst     (rst),
    .cap     (i_oe),
    .clr     (i_clr),
    .addr    (i_addr),
    .wdata   ('0),
    .we      ('0),
    .pend    (i_pend),
    .q_addr  (i_q_addr),
    .q_wdata (i_q_wdata),
    .q_we    (i_q_we)
  );

  // Dcache slot: loads and write-through
  arb_req_slot #(.ADDR_W(MEM_SCALE)) u_slot_d (
    .clk     (clk),
    .rst     (rst),
    .cap     (d_oe),
    .clr     (d_clr),
    .addr    (d_addr),
    .wdata   (d_wdata),
    .we      (d_we),
    .pend    (d_pend),
    .q_addr  (d_q_addr),
    .q_wdata (d_q_wdata),
    .q_we    (d_q_we)
  );

  // Slot clear and transaction-complete decode
  assign i_clr     = (state == ST_ISSUE) && (owner == OWN_I);
  assign d_clr     = (state == ST_ISSUE) && (owner == OWN_D);
  assign wait_done = (state == ST_WAIT) && (own_write ? mem_written : mem_valid);
  assign pick      = pick_owner(i_pend, d_pend, last_gnt);

  // Arbiter FSM with registered DRAM request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_I;
      last_gnt  <= OWN_D;
      own_write <= 1'b0;
      mem_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_pend || d_pend) begin
            owner  <= pick;
            mem_oe <= 1'b1;
            state  <= ST_ISSUE;
            if (pick == OWN_D) begin
              own_write <= (d_q_we != '0);
              mem_addr  <= d_q_addr;
              mem_wdata <= d_q_wdata;
              mem_we    <= d_q_we;
            end else begin
              own_write <= 1'b0;
              mem_addr  <= i_q_addr;
              mem_wdata <= i_q_wdata;
              mem_we    <= i_q_we;
            end
          end
        end
        ST_ISSUE: begin
          mem_oe   <= 1'b0;
          last_gnt <= owner;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          mem_oe <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Responses pass straight through to the owner of the open transaction
  assign i_valid   = mem_valid   && (state == ST_WAIT) && (owner == OWN_I);
  assign d_valid   = mem_valid   && (state == ST_WAIT) && (owner == OWN_D) && !own_write;
  assign d_written = mem_written && (state == ST_WAIT) && (owner == OWN_D) &&  own_write;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  // A request is busy while pending (except its issue cycle) or in flight (except its completion cycle)
  assign i_busy = (i_pend && !i_clr) ||
                  ((state == ST_WAIT) && (owner == OWN_I) && !wait_done);
  assign d_busy = (d_pend && !d_clr) ||
                  ((state == ST_WAIT) && (owner == OWN_D) && !wait_done);

  // Protocol check: a requester must not re-request while its previous request is outstanding
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_oe && i_busy))
        else $fatal(1, "dram_port_arbiter: i_oe while icache request outstanding");
      assert (!(d_oe && d_busy))
        else $fatal(1, "dram_port_arbiter: d_oe while dcache request outstanding");
    end
  end

`ifdef DRAM_ARB_STAT_EN
  // Grant and contention statistics, free-running with wrap-around
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_cnt_i        <= '0;
      arb_cnt_d        <= '0;
      arb_cnt_conflict <= '0;
    end else begin
      if (state == ST_ISSUE && owner == OWN_I) begin
        arb_cnt_i <= arb_cnt_i + STAT_W'(1);
      end
      if (state == ST_ISSUE && owner == OWN_D) begin
        arb_cnt_d <= arb_cnt_d + STAT_W'(1);
      end
      if (state == ST_IDLE && i_pend && d_pend) begin
        arb_cnt_conflict <= arb_cnt_conflict + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed scoreboard bench for dram_port_arbiter; build with DRAM_ARB_STAT_EN to also check counters.
module tb_dram_port_arbiter;

  localparam int unsigned AW = 27;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_oe, d_oe;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   d_wdata, mem_rdata;
  logic [3:0]    d_we;
  logic          mem_valid, mem_written;
  logic [31:0]   i_rdata, d_rdata, mem_wdata;
  logic          i_valid, d_valid, d_written, mem_oe;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
`ifdef DRAM_ARB_STAT_EN
  logic [31:0]   arb_cnt_i, arb_cnt_d, arb_cnt_conflict;
`endif

  always #5 clk = ~clk;

  dram_port_arbiter #(.MEM_SCALE(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_oe        (i_oe),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_valid     (i_valid),
    .d_oe        (d_oe),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_we        (d_we),
    .d_rdata     (d_rdata),
    .d_valid     (d_valid),
    .d_written   (d_written),
    .mem_oe      (mem_oe),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .mem_written (mem_written)
`ifdef DRAM_ARB_STAT_EN
    ,
    .arb_cnt_i        (arb_cnt_i),
    .arb_cnt_d        (arb_cnt_d),
    .arb_cnt_conflict (arb_cnt_conflict)
`endif
  );

  typedef struct {
    logic          own;   // 0 = icache, 1 = dcache
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    we;
  } txn_t;

  txn_t exp_q[$];
  txn_t last_txn;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic req_i(input logic [AW-1:0] addr);
    txn_t t;
    i_oe   = 1'b1;
    i_addr = addr;
    t.own = 1'b0; t.addr = addr; t.wdata = 32'h0; t.we = 4'h0;
    exp_q.push_back(t);
  endtask

  task automatic req_d(input logic [AW-1:0] addr, input logic [31:0] wdata, input logic [3:0] we);
    txn_t t;
    d_oe    = 1'b1;
    d_addr  = addr;
    d_wdata = wdata;
    d_we    = we;
    t.own = 1'b1; t.addr = addr; t.wdata = wdata; t.we = we;
    exp_q.push_back(t);
  endtask

  // Step until mem_oe, then check the issued transaction against the scoreboard head
  task automatic expect_issue(input string tag, input int exp_lat);
    int lat  = 0;
    bit seen = 1'b0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      i_oe = 1'b0;
      d_oe = 1'b0;
      if (mem_oe) seen = 1'b1;
    end
    chk({tag, "_issue_seen"}, 64'(seen), 64'(1));
    if (!seen) return;
    if (exp_lat > 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'(1));
    if (exp_q.size() == 0) return;
    last_txn = exp_q.pop_front();
    chk({tag, "_addr"},  64'(mem_addr),  64'(last_txn.addr));
    chk({tag, "_we"},    64'(mem_we),    64'(last_txn.we));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(last_txn.wdata));
    tick();
    chk({tag, "_oe_one_cycle"}, 64'(mem_oe), 64'(0));
  endtask

  // DRAM model: answers the last issued transaction 'delay' cycles after mem_oe
  task automatic respond(input string tag, input int delay, input logic [31:0] rdata,
                         input bit again_d, input logic [AW-1:0] again_addr);
    bit is_wr = (last_txn.we != 4'h0);
    for (int i = 1; i < delay; i++) begin
      if (is_wr && i == 1) begin
        mem_valid = 1'b1;
        #1;
        chk({tag, "_wrongkind_dvalid"}, 64'(d_valid), 64'(0));
        chk({tag, "_wrongkind_ivalid"}, 64'(i_valid), 64'(0));
        mem_valid = 1'b0;
      end
      tick();
    end
    if (is_wr) begin
      mem_written = 1'b1;
    end else begin
      mem_valid = 1'b1;
      mem_rdata = rdata;
    end
    if (again_d) req_d(again_addr, 32'h0, 4'h0);
    #1;
    chk({tag, "_i_valid"},   64'(i_valid),   64'(!is_wr && !last_txn.own));
    chk({tag, "_d_valid"},   64'(d_valid),   64'(!is_wr &&  last_txn.own));
    chk({tag, "_d_written"}, 64'(d_written), 64'(is_wr));
    if (!is_wr) begin
      chk({tag, "_i_rdata"}, 64'(i_rdata), 64'(rdata));
      chk({tag, "_d_rdata"}, 64'(d_rdata), 64'(rdata));
    end
    tick();
    mem_valid   = 1'b0;
    mem_written = 1'b0;
    d_oe        = 1'b0;
    #1;
    chk({tag, "_resp_single"}, 64'({i_valid, d_valid, d_written}), 64'(0));
  endtask

  initial begin
    rst = 1'b1; i_oe = 1'b0; d_oe = 1'b0; i_addr = '0; d_addr = '0;
    d_wdata = '0; d_we = '0; mem_rdata = '0; mem_valid = 1'b0; mem_written = 1'b0;
    do_reset();

    // Reset state
    chk("rst_mem_oe",    64'(mem_oe),    64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    chk("rst_mem_we",    64'(mem_we),    64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_resp",      64'({i_valid, d_valid, d_written}), 64'(0));
`ifdef DRAM_ARB_STAT_EN
    chk("rst_cnt", 64'({arb_cnt_i, arb_cnt_d} | 64'(arb_cnt_conflict)), 64'(0));
`endif

    // 1: icache load, two-cycle issue latency, load data routed to I
    req_i(27'h100);
    expect_issue("t1", 2);
    respond("t1", 3, 32'hDEAD_BEEF, 1'b0, '0);

    // 2: dcache partial write; a stray mem_valid during the write is ignored
    req_d(27'h204, 32'h0000_1234, 4'b0011);
    expect_issue("t2", 2);
    respond("t2", 3, 32'h0, 1'b0, '0);

    // 3: simultaneous pairs alternate ownership
    do_reset();
    req_i(27'h300);
    req_d(27'h400, 32'h0, 4'h0);
    expect_issue("t3a", 2);
    respond("t3a", 2, 32'h1111_1111, 1'b0, '0);
    expect_issue("t3b", -1);
    respond("t3b", 2, 32'h2222_2222, 1'b0, '0);
    req_i(27'h310);
    expect_issue("t3c", 2);
    respond("t3c", 2, 32'h3333_3333, 1'b0, '0);
    req_d(27'h410, 32'h0000_CAFE, 4'hF);
    req_i(27'h320);
    expect_issue("t3d", 2);
    respond("t3d", 2, 32'h0, 1'b0, '0);
    expect_issue("t3e", -1);
    respond("t3e", 2, 32'h4444_4444, 1'b0, '0);
`ifdef DRAM_ARB_STAT_EN
    chk("t3_cnt_conflict", 64'(arb_cnt_conflict), 64'(2));
    chk("t3_cnt_i",        64'(arb_cnt_i),        64'(3));
    chk("t3_cnt_d",        64'(arb_cnt_d),        64'(2));
`endif

    // 4: icache request arriving during a dcache WAIT is held until completion
    req_d(27'h500, 32'h0, 4'h0);
    expect_issue("t4d", 2);
    req_i(27'h600);
    tick();
    i_oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_held_no_oe", 64'(mem_oe), 64'(0));
      tick();
    end
    respond("t4d", 1, 32'h5555_AAAA, 1'b0, '0);
    expect_issue("t4i", -1);
    respond("t4i", 2, 32'h6666_0000, 1'b0, '0);

    // 6: dcache re-requests in the cycle its load data returns
    req_d(27'h700, 32'h0, 4'h0);
    expect_issue("t6a", 2);
    respond("t6a", 2, 32'h0000_0077, 1'b1, 27'h704);
    expect_issue("t6b", -1);
    respond("t6b", 2, 32'h0000_0078, 1'b0, '0);

    // 5: reset during WAIT, late DRAM response ignored
    req_d(27'h800, 32'h0, 4'h0);
    expect_issue("t5", 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    mem_valid = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("t5_late_ivalid", 64'(i_valid), 64'(0));
    chk("t5_late_dvalid", 64'(d_valid), 64'(0));
    tick();
    mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_oe", 64'(mem_oe), 64'(0));
      tick();
    end
    chk("t5_mem_addr", 64'(mem_addr), 64'(0));
    chk("t5_mem_we",   64'(mem_we),   64'(0));
`ifdef DRAM_ARB_STAT_EN
    chk("t5_cnt", 64'({arb_cnt_i, arb_cnt_d} | 64'(arb_cnt_conflict)), 64'(0));
`endif
    // Arbiter still serves requests after the mid-operation reset
    req_i(27'h900);
    expect_issue("t5_after", 2);
    respond("t5_after", 2, 32'h9999_0001, 1'b0, '0);

    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
